// File: rtl/cache_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_arbiter
// Description : Round-robin arbiter that shares one external burst-read
//               channel between the icache and dcache refill masters.
//               Grants one requester, forwards its line address, steers the
//               returned beats back to it until the last beat, then hands
//               priority to the other requester.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] inst_araddr,
  input  logic                  inst_arvalid,
  output logic                  inst_arready,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  output logic                  inst_rvalid,
  output logic                  inst_rlast,
  input  logic                  inst_rready,

  input  logic [ADDR_WIDTH-1:0] data_araddr,
  input  logic                  data_arvalid,
  output logic                  data_arready,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_rvalid,
  output logic                  data_rlast,
  input  logic                  data_rready,

  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  input  logic                  m_rlast,
  output logic                  m_rready,

  output logic                  grant_data,
  output logic                  busy,
  output logic                  burst_err
);

  localparam int              CNT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state;
  logic             prio_data;
  logic [CNT_W-1:0] beat_cnt;

  logic             pick_data;
  logic             in_addr;
  logic             in_data;
  logic             win_rready;
  logic             beat_hs;

  // Contention goes to the side named by prio_data; a lone request always wins.
  assign pick_data  = data_arvalid & (~inst_arvalid | prio_data);

  assign in_addr    = (state == ADDR);
  assign in_data    = (state == DATA);
  assign busy       = (state != IDLE);

  // Address phase: only the winner sees the downstream acceptance.
  assign m_arvalid    = in_addr;
  assign inst_arready = in_addr & ~grant_data & m_arready;
  assign data_arready = in_addr &  grant_data & m_arready;

  // Data phase: beats are steered to the winner; stray beats outside DATA stay unconsumed.
  assign win_rready  = grant_data ? data_rready : inst_rready;
  assign m_rready    = in_data & win_rready;
  assign beat_hs     = m_rvalid & m_rready;

  assign inst_rvalid = in_data & ~grant_data & m_rvalid;
  assign inst_rlast  = in_data & ~grant_data & m_rlast;
  assign data_rvalid = in_data &  grant_data & m_rvalid;
  assign data_rlast  = in_data &  grant_data & m_rlast;

  assign inst_rdata  = m_rdata;
  assign data_rdata  = m_rdata;

  // Arbitration FSM: grant, address latch, beat counting and sticky length-error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      prio_data  <= 1'b1;
      beat_cnt   <= '0;
      burst_err  <= 1'b0;
      grant_data <= 1'b0;
      m_araddr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_arvalid | data_arvalid) begin
            grant_data <= pick_data;
            m_araddr   <= pick_data ? data_araddr : inst_araddr;
            beat_cnt   <= '0;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (m_rlast) begin
              state     <= IDLE;
              prio_data <= ~grant_data;
              if (beat_cnt != LAST_IDX) begin
                burst_err <= 1'b1;
              end
            end else if (beat_cnt == LAST_IDX) begin
              // Downstream ran past the expected line length without rlast.
              burst_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_refill_arbiter
// Description : Self-checking bench for cache_refill_arbiter. A transaction
//               level model tracks who should win each refill, which beats
//               belong to it, and whether the line length was honoured.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_arbiter;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int BURST_LEN  = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [ADDR_WIDTH-1:0] inst_araddr = '0;
  logic                  inst_arvalid = 1'b0;
  logic                  inst_arready;
  logic [DATA_WIDTH-1:0] inst_rdata;
  logic                  inst_rvalid;
  logic                  inst_rlast;
  logic                  inst_rready = 1'b0;
  logic [ADDR_WIDTH-1:0] data_araddr = '0;
  logic                  data_arvalid = 1'b0;
  logic                  data_arready;
  logic [DATA_WIDTH-1:0] data_rdata;
  logic                  data_rvalid;
  logic                  data_rlast;
  logic                  data_rready = 1'b0;
  logic [ADDR_WIDTH-1:0] m_araddr;
  logic                  m_arvalid;
  logic                  m_arready = 1'b0;
  logic [DATA_WIDTH-1:0] m_rdata = '0;
  logic                  m_rvalid = 1'b0;
  logic                  m_rlast = 1'b0;
  logic                  m_rready;
  logic                  grant_data;
  logic                  busy;
  logic                  burst_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state: who wins the next contention, and the sticky error.
  bit prio_m = 1'b1;
  bit err_m  = 1'b0;

  cache_refill_arbiter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_araddr (inst_araddr),
    .inst_arvalid(inst_arvalid),
    .inst_arready(inst_arready),
    .inst_rdata  (inst_rdata),
    .inst_rvalid (inst_rvalid),
    .inst_rlast  (inst_rlast),
    .inst_rready (inst_rready),
    .data_araddr (data_araddr),
    .data_arvalid(data_arvalid),
    .data_arready(data_arready),
    .data_rdata  (data_rdata),
    .data_rvalid (data_rvalid),
    .data_rlast  (data_rlast),
    .data_rready (data_rready),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rvalid    (m_rvalid),
    .m_rlast     (m_rlast),
    .m_rready    (m_rready),
    .grant_data  (grant_data),
    .busy        (busy),
    .burst_err   (burst_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},    busy, 0);
    check({tag, "_arvalid"}, m_arvalid, 0);
    check({tag, "_rready"},  m_rready, 0);
    check({tag, "_arready"}, {inst_arready, data_arready}, 0);
    check({tag, "_rvalid"},  {inst_rvalid, data_rvalid}, 0);
    check({tag, "_rlast"},   {inst_rlast, data_rlast}, 0);
  endtask

  // One refill transaction, entered and left on a falling edge with the arbiter idle.
  task automatic run_burst(input bit ri, input bit rd,
                           input logic [31:0] ai, input logic [31:0] ad,
                           input int ard, input int nb,
                           input int stall_pct, input int gap_pct, input int stall_beat,
                           input bit keep, input int abort_at);
    bit          wd;
    logic [31:0] wa;
    logic [31:0] beat;
    int          k;
    int          hold;
    int          budget;
    bit          gap;
    bit          rr;
    wd = (ri && rd) ? prio_m : rd;
    wa = wd ? ad : ai;

    check("idle_busy", busy, 0);
    inst_arvalid = ri; inst_araddr = ai;
    data_arvalid = rd; data_araddr = ad;
    m_arready = 1'b0;
    @(negedge clk);

    check("grant", grant_data, wd);
    check("m_araddr", m_araddr, wa);
    check("m_arvalid_up", m_arvalid, 1);
    check("busy_up", busy, 1);
    if (!keep) begin
      if (wd) inst_arvalid = 1'b0; else data_arvalid = 1'b0;
    end

    for (int i = 0; i <= ard; i++) begin
      m_arready = (i == ard);
      m_rvalid  = 1'($urandom_range(0, 1));
      m_rlast   = 1'($urandom_range(0, 1));
      #1;
      check("m_arvalid_hold", m_arvalid, 1);
      check("win_arready", wd ? data_arready : inst_arready, (i == ard));
      check("lose_arready", wd ? inst_arready : data_arready, 0);
      check("addr_rready", m_rready, 0);
      check("addr_rvalid", {inst_rvalid, data_rvalid}, 0);
      @(negedge clk);
    end
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    if (wd) data_arvalid = 1'b0; else inst_arvalid = 1'b0;
    #1;
    check("data_arvalid_low", m_arvalid, 0);
    check("data_busy", busy, 1);

    k = 0; hold = 0; budget = 0;
    while (k < nb && budget < 400) begin
      if (k == abort_at) begin
        rst = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = $urandom;
        inst_rready = 1'b1; data_rready = 1'b1;
        @(negedge clk);
        rst = 1'b1; inst_arvalid = 1'b0; data_arvalid = 1'b0;
        #1;
        check_quiet("abort");
        check("abort_err", burst_err, 0);
        prio_m = 1'b1; err_m = 1'b0;
        m_rvalid = 1'b0;
        @(negedge clk);
        return;
      end
      gap = 1'b0; rr = 1'b1;
      if (k == stall_beat && hold < 3) begin
        rr = 1'b0; hold++;
      end else begin
        gap = ($urandom_range(0, 99) < gap_pct);
        rr  = ($urandom_range(0, 99) >= stall_pct);
      end
      beat     = $urandom;
      m_rvalid = !gap;
      m_rdata  = beat;
      m_rlast  = !gap && (k == nb - 1);
      if (wd) begin data_rready = rr; inst_rready = 1'($urandom_range(0, 1)); end
      else    begin inst_rready = rr; data_rready = 1'($urandom_range(0, 1)); end
      #1;
      check("win_rvalid", wd ? data_rvalid : inst_rvalid, !gap);
      check("win_rlast", wd ? data_rlast : inst_rlast, !gap && (k == nb - 1));
      check("lose_rvalid", wd ? inst_rvalid : data_rvalid, 0);
      check("lose_rlast", wd ? inst_rlast : data_rlast, 0);
      check("m_rready", m_rready, rr);
      check("inst_rdata", inst_rdata, beat);
      check("data_rdata", data_rdata, beat);
      if (!gap && rr) k++;
      budget++;
      @(negedge clk);
    end
    if (budget >= 400) check("beat_timeout", k, nb);
    m_rvalid = 1'b0; m_rlast = 1'b0;

    err_m  = err_m | (nb != BURST_LEN);
    prio_m = !wd;
    #1;
    check("done_busy", busy, 0);
    check("burst_err", burst_err, err_m);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_err", burst_err, 0);
    check("reset_grant", grant_data, 0);
    check("reset_araddr", m_araddr, 0);
    rst = 1'b1;
    @(negedge clk);

    // Lone icache refill of line 0x40.
    run_burst(1, 0, 32'h0000_0040, 32'h0, 2, 8, 0, 0, -1, 0, -1);

    // Simultaneous requests held continuously: data, inst, data, inst.
    run_burst(1, 1, 32'h1000_0000, 32'h2000_0000, 1, 8, 0, 0, -1, 1, -1);
    run_burst(1, 1, 32'h1000_0020, 32'h2000_0020, 0, 8, 0, 0, -1, 1, -1);
    run_burst(1, 1, 32'h1000_0040, 32'h2000_0040, 2, 8, 0, 0, -1, 1, -1);
    run_burst(1, 1, 32'h1000_0060, 32'h2000_0060, 0, 8, 0, 0, -1, 0, -1);

    // Winner stalls three cycles in the middle of a burst.
    run_burst(0, 1, 32'h0, 32'h3000_0100, 0, 8, 0, 0, 4, 0, -1);

    // Early rlast on beat 5, then a clean burst with the flag staying set.
    run_burst(1, 0, 32'h4000_0000, 32'h0, 1, 6, 0, 0, -1, 0, -1);
    run_burst(0, 1, 32'h0, 32'h5000_0000, 0, 8, 10, 10, -1, 0, -1);

    // Reset in the middle of beat 3, then contention must favour data again.
    run_burst(1, 0, 32'h6000_0000, 32'h0, 0, 8, 0, 0, -1, 0, 3);
    run_burst(1, 1, 32'h7000_0000, 32'h7800_0000, 1, 8, 0, 0, -1, 0, -1);

    // Randomised traffic.
    for (int r = 0; r < 40; r++) begin
      v = $urandom_range(1, 3);
      run_burst(v[0], v[1], $urandom & 32'hFFFF_FFE0, $urandom & 32'hFFFF_FFE0,
                $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : BURST_LEN,
                25, 25, -1, 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
Shares the single external burst-read channel between the instruction-cache and data-cache refill masters. Grants one requester at a time and issues its line address downstream. It routes returned beats back to the winner until the last-beat handshake, then hands the channel to the other requester by round-robin. It sits between the two caches' read-miss ports and the SRAM/AXI bridge read port.

Parameters:
ADDR_WIDTH, 32, width of all araddr buses
DATA_WIDTH, 32, width of all rdata buses
BURST_LEN, 8, beats per refill line (8 words = 32-byte line); power of two, 2..16

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
inst_araddr  in  ADDR_WIDTH  icache refill line address
inst_arvalid  in  1  icache refill request
inst_arready  out  1  icache address accepted
inst_rdata  out  DATA_WIDTH  returned beat data
inst_rvalid  out  1  beat valid for icache
inst_rlast  out  1  last beat for icache
inst_rready  in  1  icache can accept beat
data_araddr  in  ADDR_WIDTH  dcache refill line address
data_arvalid  in  1  dcache refill request
data_arready  out  1  dcache address accepted
data_rdata  out  DATA_WIDTH  returned beat data
data_rvalid  out  1  beat valid for dcache
data_rlast  out  1  last beat for dcache
data_rready  in  1  dcache can accept beat
m_araddr  out  ADDR_WIDTH  downstream read address
m_arvalid  out  1  downstream address valid
m_arready  in  1  downstream address accepted
m_rdata  in  DATA_WIDTH  downstream beat data
m_rvalid  in  1  downstream beat valid
m_rlast  in  1  downstream last beat
m_rready  out  1  arbiter accepts beat
grant_data  out  1  1 = dcache owns channel, 0 = icache (meaningful when busy)
busy  out  1  state != IDLE
burst_err  out  1  sticky: rlast beat count mismatch

Behaviour:
- States: IDLE, ADDR, DATA. Registered state, grant, priority pointer prio_data, latched address, beat counter, burst_err.
- Reset (rst=0 at edge): state=IDLE, prio_data=1, beat_cnt=0, burst_err=0, grant_data=0, m_araddr=0. All valid, ready, last and busy outputs read 0 in IDLE. Reset mid-burst aborts immediately; any further downstream beats are ignored (m_rready=0).
- IDLE: if only one arvalid is high, grant it. If both are high, grant data when prio_data=1, else inst. At the edge: latch the winner's araddr into m_araddr, set grant_data, clear beat_cnt, go to ADDR. m_arvalid rises the cycle after the request is first seen (1-cycle latency).
- ADDR: m_arvalid=1, m_araddr stable. Winner's arready = m_arready (combinational); loser's arready=0. On m_arready=1, go to DATA. Requesters must hold arvalid/araddr until arready; the arbiter does not re-sample the address.
- DATA: m_rready = winner's rready. Winner's rvalid=m_rvalid, rlast=m_rlast. Loser's rvalid and rlast = 0. m_rdata fans out to both rdata buses unconditionally.
- Beat handshake = m_rvalid & m_rready; it increments beat_cnt (width clog2(BURST_LEN)+1).
- On a handshake with m_rlast=1: go to IDLE and set prio_data = ~grant_data (the other requester wins the next contention). If beat_cnt != BURST_LEN-1 at that beat, set burst_err=1 (cleared only by reset).
- A handshake with beat_cnt = BURST_LEN-1 and m_rlast=0 also sets burst_err. The burst continues until rlast.
- In IDLE and ADDR, m_rready=0; stray m_rvalid is not consumed and not forwarded.
- Back-to-back: returning to IDLE costs one cycle. A pending loser request is granted at that IDLE edge; its m_arvalid rises 2 cycles after the winner's last beat.
- A requester that drops arvalid before its grant is simply not granted. No starvation: with both requesting continuously, grants strictly alternate.

Test Plan:
- Single icache request, araddr=0x0000_0040, m_arready after 2 cycles, 8 beats with rlast on beat 7 -> m_araddr=0x40, inst_rvalid 8 times, data_rvalid=0 throughout, busy drops the cycle after last beat, burst_err=0.
- Both arvalid in the same cycle after reset -> dcache granted first (grant_data=1). Icache granted next; m_arvalid rises 2 cycles after the dcache rlast beat.
- Both requesting continuously for 4 bursts -> grant order data, inst, data, inst.
- Winner holds rready=0 for 3 cycles mid-burst while m_rvalid=1 -> m_rready=0 those cycles, no beat lost, beat_cnt unchanged.
- Downstream asserts rlast on beat 5 (BURST_LEN=8) -> burst ends and returns to IDLE, burst_err=1 and stays 1 until rst=0.
- rst=0 during DATA beat 3 -> next cycle busy=0, all valid/ready outputs 0, prio_data=1, burst_err=0.
